// File: rtl/dump_seq_ctrl.sv
// dump_seq_ctrl: NMR dump-switch sequencer, DELAY -> (ON -> DEAD -> OFF -> DEAD) x (REP+1).
// Optional watchdog on continuous dump_on enabled by defining DUMP_WDOG_EN.
module dump_seq_ctrl #(
  parameter int PARA_W   = 12,
  parameter int CHOICE_W = 3,
  parameter int REP_W    = 4,
  parameter int MAX_ON   = 4000
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic                state_start,
  input  logic                dump_load,
  input  logic [CHOICE_W-1:0] dump_choice,
  input  logic [PARA_W-1:0]   dump_para,
  input  logic                pluse_start,
  input  logic                bri_cycle,
  output logic                dump_on,
  output logic                dump_off,
  output logic                busy,
  output logic                done,
  output logic                fault
);
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DLY, S_ON, S_DT1, S_OFF, S_DT2} state_t;
  state_t r_state, w_next;
  logic [PARA_W-1:0] r_delay, r_on_w, r_dead, r_off_w, r_s_on, r_s_dead, r_s_off, r_cnt;
  logic [REP_W-1:0]  r_rep, r_rep_cnt, w_rep_nxt;
  logic              r_mode;
  logic [PARA_W-1:0] w_d [8];
  logic [4:0]        w_nz;
  logic [2:0]        w_pos, w_p;
  logic              w_run, w_trig, w_end, w_step, w_fin, w_wd_trip, w_on, w_off, w_busy;
  // Timed-phase positions 0..4 = DLY,ON,DT1,OFF,DT2; 5 means "sequence exhausted".
  function automatic logic [2:0] first_nz(input logic [2:0] from, input logic [4:0] nz);
    first_nz = 3'd5;
    for (int k = 4; k >= 0; k--) if (k >= int'(from) && nz[k]) first_nz = 3'(k);
  endfunction
  assign w_run  = r_state >= S_DLY;
  assign w_pos  = 3'(r_state) - 3'd2;
  assign w_end  = w_run && r_cnt == '0;
  assign w_trig = r_state == S_ARMED && !done && !fault && (r_mode ? bri_cycle : pluse_start);
  // The trigger cycle still sees live registers; afterwards only the shadows are used.
  assign w_d[0] = r_delay;
  assign w_d[1] = w_trig ? r_on_w : r_s_on;
  assign w_d[2] = w_trig ? r_dead : r_s_dead;
  assign w_d[3] = w_trig ? r_off_w : r_s_off;
  assign w_d[4] = w_d[2];
  assign w_d[5] = '0;
  assign w_d[6] = '0;
  assign w_d[7] = '0;
  assign w_nz   = {|w_d[4], |w_d[3], |w_d[2], |w_d[1], |w_d[0]};
  always_comb begin
    w_rep_nxt = w_trig ? r_rep : r_rep_cnt;
    w_p = first_nz(w_trig ? 3'd0 : w_pos + 3'd1, w_nz);
    if (w_end && w_p == 3'd5 && r_rep_cnt != '0) begin
      w_p = first_nz(3'd1, w_nz);
      w_rep_nxt = r_rep_cnt - 1'b1;
    end
    w_step = w_trig || w_end;
    w_fin = w_step && w_p == 3'd5;
    w_next = (!state_start || w_wd_trip) ? S_IDLE :
             w_step ? (w_fin ? S_ARMED : state_t'(w_p + 3'd2)) :
             r_state == S_IDLE ? S_ARMED : r_state;
  end
  always_comb begin
    w_on = w_next == S_ON;
    w_off = w_next == S_OFF;
    w_busy = w_next >= S_DLY;
  end
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      {r_delay, r_on_w, r_dead, r_off_w, r_s_on, r_s_dead, r_s_off, r_cnt} <= '0;
      {r_rep, r_rep_cnt, r_mode} <= '0;
      {dump_on, dump_off, busy, done} <= '0;
    end else begin
      if (dump_load && dump_choice == CHOICE_W'(0)) r_delay <= dump_para;
      if (dump_load && dump_choice == CHOICE_W'(1)) r_on_w <= dump_para;
      if (dump_load && dump_choice == CHOICE_W'(2)) r_dead <= dump_para;
      if (dump_load && dump_choice == CHOICE_W'(3)) r_off_w <= dump_para;
      if (dump_load && dump_choice == CHOICE_W'(4)) r_rep <= dump_para[REP_W-1:0];
      if (dump_load && dump_choice == CHOICE_W'(5)) r_mode <= dump_para[0];
      if (w_trig) {r_s_on, r_s_dead, r_s_off} <= {r_on_w, r_dead, r_off_w};
      r_state <= w_next;
      r_rep_cnt <= w_rep_nxt;
      r_cnt <= (w_step && !w_fin) ? w_d[w_p] - 1'b1 : (w_run && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
      dump_on <= w_on;
      dump_off <= w_off;
      busy <= w_busy;
      done <= w_fin && state_start && !w_wd_trip;
    end
  end
`ifdef DUMP_WDOG_EN
  localparam int WD_W = $clog2(MAX_ON + 1);
  logic [WD_W-1:0] r_wd;
  assign w_wd_trip = dump_on && r_wd == WD_W'(MAX_ON - 1);
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_wd <= '0;
      fault <= 1'b0;
    end else begin
      r_wd <= dump_on ? r_wd + 1'b1 : '0;
      fault <= fault | w_wd_trip;
    end
  end
`else
  assign w_wd_trip = 1'b0;
  assign fault = 1'b0;
  if (MAX_ON < 1) begin : g_max_on_chk
    $error("MAX_ON must be positive");
  end
`endif
endmodule

// File: tb/tb_dump_seq_ctrl.sv
// tb_dump_seq_ctrl: directed + randomized checks of dump_seq_ctrl against a per-cycle
// expected waveform built from the register values.
module tb_dump_seq_ctrl;
  logic clk_sys = 0, rst_n = 0, state_start = 0, dump_load = 0, pluse_start = 0, bri_cycle = 0;
  logic [2:0]  dump_choice = 0;
  logic [11:0] dump_para = 0;
  logic dump_on, dump_off, busy, done, fault;
  int total = 0, bad = 0, mode_q = 0;

  always #5 clk_sys = ~clk_sys;

  dump_seq_ctrl #(.PARA_W(12), .CHOICE_W(3), .REP_W(4), .MAX_ON(8)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .state_start(state_start), .dump_load(dump_load),
    .dump_choice(dump_choice), .dump_para(dump_para), .pluse_start(pluse_start),
    .bri_cycle(bri_cycle), .dump_on(dump_on), .dump_off(dump_off), .busy(busy),
    .done(done), .fault(fault));

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int idx, input int val);
    dump_load = 1; dump_choice = 3'(idx); dump_para = 12'(val);
    tick;
    dump_load = 0;
  endtask

  task automatic config_regs(input int d, input int on, input int dd, input int off, input int rep, input int mode);
    load(0, d); load(1, on); load(2, dd); load(3, off); load(4, rep); load(5, mode);
    mode_q = mode;
  endtask

  // Expected per-cycle {dump_on,dump_off} after the trigger, then a done cycle.
  task automatic run_seq(input string tag, input int d, input int on, input int dd, input int off,
                         input int rep, input int disturb_at, input int reload_at, input int reload_val);
    logic [1:0] exp_q[$];
    for (int i = 0; i < d; i++) exp_q.push_back(2'b00);
    for (int r = 0; r <= rep; r++) begin
      repeat (on) exp_q.push_back(2'b10);
      repeat (dd) exp_q.push_back(2'b00);
      repeat (off) exp_q.push_back(2'b01);
      repeat (dd) exp_q.push_back(2'b00);
    end
    if (mode_q != 0) pluse_start = 1; else bri_cycle = 1;
    tick;
    pluse_start = 0; bri_cycle = 0;
    chk($sformatf("%s wrong-strobe busy", tag), busy, 0);
    if (mode_q != 0) bri_cycle = 1; else pluse_start = 1;
    tick;
    pluse_start = 0; bri_cycle = 0;
    foreach (exp_q[i]) begin
      chk($sformatf("%s on[%0d]", tag, i), dump_on, exp_q[i][1]);
      chk($sformatf("%s off[%0d]", tag, i), dump_off, exp_q[i][0]);
      chk($sformatf("%s busy[%0d]", tag, i), busy, 1);
      chk($sformatf("%s done[%0d]", tag, i), done, 0);
      chk($sformatf("%s fault[%0d]", tag, i), fault, 0);
      if (i == disturb_at) begin pluse_start = 1; bri_cycle = 1; end
      if (i == reload_at) begin dump_load = 1; dump_choice = 3'd1; dump_para = 12'(reload_val); end
      tick;
      pluse_start = 0; bri_cycle = 0; dump_load = 0;
    end
    chk($sformatf("%s done", tag), done, 1);
    chk($sformatf("%s done-busy", tag), busy, 0);
    chk($sformatf("%s done-outs", tag), {dump_on, dump_off}, 0);
    if (mode_q != 0) bri_cycle = 1; else pluse_start = 1;
    tick;
    pluse_start = 0; bri_cycle = 0;
    chk($sformatf("%s post-done", tag), done, 0);
    chk($sformatf("%s trig-on-done busy", tag), busy, 0);
  endtask

  initial begin
    int d, on, dd, off, rep, len;
    tick; tick;
    chk("reset on", dump_on, 0);
    chk("reset off", dump_off, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset fault", fault, 0);
    rst_n = 1;
    repeat (3) tick;
    chk("idle outs", {dump_on, dump_off, busy, done, fault}, 0);
    state_start = 1;
    config_regs(3, 5, 2, 4, 0, 0);
    run_seq("basic", 3, 5, 2, 4, 0, -1, -1, 0);
    config_regs(1, 2, 1, 3, 2, 1);
    run_seq("bri_rep", 1, 2, 1, 3, 2, 4, -1, 0);
    config_regs(0, 0, 0, 0, 1, 0);
    run_seq("all_zero", 0, 0, 0, 0, 1, -1, -1, 0);
    config_regs(2, 0, 3, 0, 1, 0);
    run_seq("timing_only", 2, 0, 3, 0, 1, -1, -1, 0);
    config_regs(1, 3, 0, 2, 1, 0);
    run_seq("no_dead", 1, 3, 0, 2, 1, -1, -1, 0);

    // state_start dropped during ON
    config_regs(2, 5, 1, 3, 0, 0);
    pluse_start = 1; tick; pluse_start = 0;
    tick; tick;
    chk("drop pre on", dump_on, 1);
    state_start = 0;
    tick;
    chk("drop on", dump_on, 0);
    chk("drop busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("drop quiet[%0d]", i), {dump_on, dump_off, done}, 0);
      tick;
    end
    state_start = 1;
    tick;

    // ON_W rewritten mid-run affects only the next trigger
    config_regs(0, 5, 1, 2, 0, 0);
    run_seq("reload_a", 0, 5, 1, 2, 0, -1, 2, 9);
    run_seq("reload_b", 0, 9, 1, 2, 0, -1, -1, 0);

    for (int t = 0; t < 12; t++) begin
      d = $urandom_range(0, 4); on = $urandom_range(0, 6); dd = $urandom_range(0, 3);
      off = $urandom_range(0, 6); rep = $urandom_range(0, 3);
      len = d + (rep + 1) * (on + 2 * dd + off);
      config_regs(d, on, dd, off, rep, $urandom_range(0, 1));
      run_seq($sformatf("rnd%0d", t), d, on, dd, off, rep, $urandom_range(0, len), -1, 0);
    end

    // asynchronous reset mid-sequence
    config_regs(0, 6, 1, 1, 0, 0);
    pluse_start = 1; tick; pluse_start = 0;
    tick;
    chk("arst pre on", dump_on, 1);
    #3 rst_n = 0;
    #1;
    chk("arst on", dump_on, 0);
    chk("arst busy", busy, 0);
    tick;
    rst_n = 1;
    tick;

    config_regs(0, 20, 1, 2, 0, 0);
`ifdef DUMP_WDOG_EN
    pluse_start = 1; tick; pluse_start = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wdog on[%0d]", i), dump_on, 1);
      tick;
    end
    chk("wdog cut", dump_on, 0);
    chk("wdog fault", fault, 1);
    chk("wdog busy", busy, 0);
    chk("wdog done", done, 0);
    repeat (3) tick;
    pluse_start = 1; tick; pluse_start = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wdog ignore[%0d]", i), {busy, dump_on}, 0);
      chk($sformatf("wdog sticky[%0d]", i), fault, 1);
      tick;
    end
`else
    run_seq("long_on", 0, 20, 1, 2, 0, -1, -1, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
